// File: rtl/timedisk_block_reader.sv
// Bus initiator for the TimeDisk slot card: builds 7-clock 6502-style bus frames on C7M
// and runs the block-read sequence (IOSEL enable, 3 address writes, N data reads).
module timedisk_block_reader #(
  parameter int SLOT  = 7,
  parameter int LEN_W = 16
) (
  input  logic             C7M,
  input  logic             nRES,
  input  logic             start,
  input  logic [19:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic [7:0]       rdata,
  output logic             rvalid,
  output logic             done,
  output logic             PHI1,
  output logic [15:0]      A,
  output logic             nWE,
  output logic [7:0]       D_o,
  output logic             D_oe,
  input  logic [7:0]       D_i,
  output logic             nDEVSEL,
  output logic             nIOSEL,
  output logic             nIOSTRB
);

  localparam logic [15:0] DEVSEL_BASE = 16'hC080 + 16'(SLOT * 16);
  localparam logic [15:0] IOSEL_PAGE  = 16'hC000 + 16'(SLOT * 256);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_ENREG, S_WRL, S_WRM, S_WRH, S_READ, S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [2:0]       p, p_nx;
  logic [19:0]      addr_q;
  logic [LEN_W-1:0] cnt;

  logic        frame_end, strobe_on, data_on;
  logic [15:0] a_nx;
  logic        we_nx, dsel_nx, isel_nx, doe_nx;
  logic [7:0]  wdata, do_nx;

  // Frame-op transitions happen only at a frame boundary (P 6->0), except
  // the start acceptance and the single-clock DONE step.
  always_comb begin
    frame_end = (p == 3'd6);
    p_nx      = frame_end ? 3'd0 : p + 3'd1;
    state_nx  = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_ARM;
      S_ARM:   if (frame_end) state_nx = S_ENREG;
      S_ENREG: if (frame_end) state_nx = S_WRL;
      S_WRL:   if (frame_end) state_nx = S_WRM;
      S_WRM:   if (frame_end) state_nx = S_WRH;
      S_WRH:   if (frame_end) state_nx = (cnt == '0) ? S_DONE : S_READ;
      S_READ:  if (frame_end && cnt == LEN_W'(1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    // Bus outputs are computed for the phase the counter is about to enter.
    strobe_on = (p_nx >= 3'd3);
    data_on   = (p_nx >= 3'd4);
    a_nx      = 16'h0000;
    we_nx     = 1'b1;
    dsel_nx   = 1'b1;
    isel_nx   = 1'b1;
    wdata     = 8'h00;
    case (state_nx)
      S_ENREG: begin
        a_nx    = IOSEL_PAGE;
        isel_nx = !strobe_on;
      end
      S_WRL: begin
        a_nx    = DEVSEL_BASE;
        we_nx   = 1'b0;
        dsel_nx = !strobe_on;
        wdata   = addr_q[7:0];
      end
      S_WRM: begin
        a_nx    = DEVSEL_BASE + 16'd1;
        we_nx   = 1'b0;
        dsel_nx = !strobe_on;
        wdata   = addr_q[15:8];
      end
      S_WRH: begin
        a_nx    = DEVSEL_BASE + 16'd2;
        we_nx   = 1'b0;
        dsel_nx = !strobe_on;
        wdata   = {4'h0, addr_q[19:16]};
      end
      S_READ: begin
        a_nx    = DEVSEL_BASE + 16'd3;
        dsel_nx = !strobe_on;
      end
      default: ;
    endcase
    doe_nx = !we_nx && data_on;
    do_nx  = doe_nx ? wdata : 8'h00;
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      state   <= S_IDLE;
      p       <= 3'd0;
      addr_q  <= 20'h0;
      cnt     <= '0;
      busy    <= 1'b0;
      rdata   <= 8'h00;
      rvalid  <= 1'b0;
      done    <= 1'b0;
      PHI1    <= 1'b1;
      A       <= 16'h0000;
      nWE     <= 1'b1;
      D_o     <= 8'h00;
      D_oe    <= 1'b0;
      nDEVSEL <= 1'b1;
      nIOSEL  <= 1'b1;
      nIOSTRB <= 1'b1;
    end else begin
      state   <= state_nx;
      p       <= p_nx;
      PHI1    <= (p_nx <= 3'd2);
      A       <= a_nx;
      nWE     <= we_nx;
      D_o     <= do_nx;
      D_oe    <= doe_nx;
      nDEVSEL <= dsel_nx;
      nIOSEL  <= isel_nx;
      nIOSTRB <= 1'b1;
      rvalid  <= 1'b0;
      done    <= 1'b0;
      if (state == S_IDLE && start) begin
        busy   <= 1'b1;
        addr_q <= addr;
        cnt    <= len;
      end
      // Read data is taken on the edge closing the READ frame.
      if (state == S_READ && frame_end) begin
        rdata  <= D_i;
        rvalid <= 1'b1;
        cnt    <= cnt - LEN_W'(1);
      end
      if (state == S_DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: doc/timedisk_block_reader.md
# timedisk_block_reader

Host-side bus initiator for the TimeDisk slot card, used as a bench model and as the bus-master core for a future DMA/loader board. It generates Apple II 6502-style bus frames on C7M (PHI1, A, nWE, D, nDEVSEL, nIOSEL, nIOSTRB) and runs the card's block-read protocol:
- enable the card registers with an nIOSEL access;
- load the 20-bit address register;
- stream N bytes from the auto-incrementing RAM data register.

## Interface
Parameters:
- SLOT, 7, slot number 1..7; sets the DEVSEL base $C080+16*SLOT and the IOSEL page $Cs00.
- LEN_W, 16, width of the transfer length.

Ports:
- C7M  in  1  7 MHz clock; all logic on posedge.
- nRES  in  1  asynchronous active-low reset.
- start  in  1  request pulse, sampled while busy=0.
- addr  in  20  SRAM start address.
- len  in  LEN_W  byte count.
- busy  out  1  high from start acceptance until done.
- rdata  out  8  read byte.
- rvalid  out  1  one-clock strobe qualifying rdata.
- done  out  1  one-clock strobe at end of transfer.
- PHI1  out  1  bus phase 1.
- A  out  16  bus address.
- nWE  out  1  bus R/W; 1 means read.
- D_o  out  8  write data.
- D_oe  out  1  write-data enable.
- D_i  in  8  bus read data.
- nDEVSEL, nIOSEL, nIOSTRB  out  1 each  card selects, active low.

## Operation
- Free-running frame counter P counts 0..6 and wraps to 0; it runs regardless of activity.
  - PHI1 = 1 for P = 0..2.
  - PHI1 = 0 for P = 3..6.
- One bus operation occupies exactly one frame. Operations start only at P=0.
- Frame contents:
  - A and nWE are valid for P = 0..6.
  - The selected strobe is low for P = 3..6.
  - On writes, D_oe = 1 and D_o is valid for P = 4..6.
- Idle frame: A = 16'h0000, nWE = 1, all strobes high, D_oe = 0, D_o = 0.
- Read data: D_i is captured on the edge that ends P=6 (P 6→0). It is presented on rdata with rvalid = 1 for that one clock.
- State machine:
  - IDLE → ARM when start = 1 and busy = 0. addr and len are latched on that edge and busy rises on it.
  - ARM: wait for the next P=0.
  - ENREG: IOSEL read at $Cs00; data discarded, no rvalid.
  - WRL: DEVSEL write, base+0, data addr[7:0].
  - WRM: DEVSEL write, base+1, data addr[15:8].
  - WRH: DEVSEL write, base+2, data {4'h0, addr[19:16]}.
  - READ: DEVSEL read at base+3, repeated len times back-to-back with no idle frames; rvalid on each.
  - DONE: one clock. done = 1, busy drops to 0, then return to IDLE.
- Write order L, M, H is mandatory. A later write overrides any increment spuriously triggered by an earlier one.
- Length and counter rules:
  - len = 0: setup frames run, no READ frames, done follows WRH.
  - The remaining-byte counter is LEN_W bits and decrements per READ frame. It never wraps.
  - len = 2^LEN_W−1 is legal.
- start while busy = 1 is ignored, as are addr/len changes during busy.
- Reset (asynchronous, any time including mid-frame): state IDLE, P = 0, PHI1 = 1, A = 0, nWE = 1, all strobes = 1, D_oe = 0, D_o = 0, rdata = 0, rvalid = 0, done = 0, busy = 0. No partial frame completes.

## Timing
- All outputs are registered. Bus outputs change only on posedge C7M.
- Latency from the accepting edge to the ENREG frame start: 1..7 clocks (next P=0).
- Frame k of the sequence starts 7·k clocks after ENREG start (ENREG k=0, WRL 1, WRM 2, WRH 3, first READ 4).
- First rvalid: at the end of frame 4, i.e. 35 clocks after ENREG start.
- Subsequent rvalid strobes: every 7 clocks.
- done: the clock after the final rvalid (len = 0: the clock after WRH ends). busy falls with done.
- Minimum back-to-back: a new start is accepted on the clock after done.

## Test plan
- SLOT=7, start with addr = 20'h12345, len = 3, card model returns 8'hA1, 8'hB2, 8'hC3:
  - bus shows IOSEL read $C700;
  - writes $C0F0 = 8'h45, $C0F1 = 8'h23, $C0F2 = 8'h01;
  - three reads at $C0F3;
  - rvalid strobes with rdata A1, B2, C3, 7 clocks apart;
  - done once; busy spans start to done.
- PHI1/strobe shape in any frame: PHI1 = 1,1,1,0,0,0,0; strobe low only for P = 3..6; D_oe only for P = 4..6 on writes.
- len = 0, addr = 20'hFFFFF: 4 setup frames, WRH data 8'h0F, no rvalid, done the clock after WRH ends.
- start asserted again during a transfer with a different addr: ignored; the in-flight sequence is unchanged.
- nRES pulsed low at P=4 of the second READ frame of a len = 5 transfer: all outputs take reset values immediately; no further rvalid; a new start after release runs a full sequence from ENREG.
- start at each of the 7 P phases: ENREG begins at the next P=0; latency is 1..7 clocks.
